alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one register-to-register instruction at a time to an
// external ALU. The sequence is IDLE -> EXEC -> DONE, so one instruction
// completes every three cycles. The block also holds a 4-entry register file
// with a host preload port, and a sticky overflow flag.
// Optional feature macro: ALU_OVF_TRAP_EN. When it is defined, an overflowing
// result is not written back to the register file.
module alu_issue_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_func,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_ovf,
    input  logic              host_we,
    input  logic [1:0]        host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [1:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              result_ovf,
    output logic              ovf_sticky,
    input  logic              ovf_clr
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] alu_a_q, alu_b_q, result_q;
    logic [3:0]        alu_func_q;
    logic [1:0]        rd_q;
    logic              done_q, result_ovf_q, ovf_sticky_q;
    logic              accept, exec_close, wb_en;

    // Bits [5:0] of the instruction word carry no information.
    logic              unused_instr_bits;
    assign unused_instr_bits = ^instr[5:0];

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        exec_close = 1'b0;
        wb_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                exec_close = 1'b1;
`ifdef ALU_OVF_TRAP_EN
                wb_en      = ~alu_ovf;
`else
                wb_en      = 1'b1;
`endif
                state_d    = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Register file. If the host writes the same register on the edge where
    // the writeback happens, the writeback wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wb_en && rd_q == 2'(i))
                    rf_q[i] <= alu_c;
                else if (host_we && host_addr == 2'(i))
                    rf_q[i] <= host_wdata;
            end
        end
    end

    // Operand and function latch at acceptance. These values hold outside EXEC.
    // The register file is read here, so every earlier writeback is already seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_func_q <= 4'b1111;
            rd_q       <= 2'd0;
        end else if (accept) begin
            alu_a_q    <= rf_q[instr[11:10]];
            alu_b_q    <= rf_q[instr[9:8]];
            alu_func_q <= instr[15:12];
            rd_q       <= instr[7:6];
        end
    end

    // Completion: capture the result, then pulse done for the DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q     <= '0;
            result_ovf_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= exec_close;
            if (exec_close) begin
                result_q     <= alu_c;
                result_ovf_q <= alu_ovf;
            end
        end
    end

    // Sticky overflow flag. A set takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        ovf_sticky_q <= 1'b0;
        else if (exec_close && alu_ovf)   ovf_sticky_q <= 1'b1;
        else if (ovf_clr)                 ovf_sticky_q <= 1'b0;
    end

    assign instr_ready = (state_q == IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_func    = alu_func_q;
    assign rd_data     = rf_q[rd_addr];
    assign done        = done_q;
    assign result      = result_q;
    assign result_ovf  = result_ovf_q;
    assign ovf_sticky  = ovf_sticky_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. It models the external ALU and keeps a
// transaction-level reference model of the register file and flags.
module tb_alu_issue_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [15:0]  instr = '0;
    logic [W-1:0] alu_a, alu_b, alu_c;
    logic [3:0]   alu_func;
    logic         alu_ovf;
    logic         host_we = 1'b0;
    logic [1:0]   host_addr = '0;
    logic [W-1:0] host_wdata = '0;
    logic [1:0]   rd_addr = '0;
    logic [W-1:0] rd_data;
    logic         done;
    logic [W-1:0] result;
    logic         result_ovf;
    logic         ovf_sticky;
    logic         ovf_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state.
    logic [W-1:0] m_rf [4];
    logic         m_sticky;
    logic [W-1:0] m_result;
    logic         m_rovf;

    alu_issue_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_c(alu_c), .alu_ovf(alu_ovf), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .rd_addr(rd_addr), .rd_data(rd_data), .done(done),
        .result(result), .result_ovf(result_ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: add/sub report signed overflow; the other ops never overflow.
    function automatic logic [W:0] alu_ref(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, s;
        logic [W-1:0] c;
        logic v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        v  = 1'b0;
        case (f)
            4'd0: begin s = sa + sb; c = W'(s); v = (s > 32767) || (s < -32768); end
            4'd1: begin s = sa - sb; c = W'(s); v = (s > 32767) || (s < -32768); end
            4'd2: c = a & b;
            4'd3: c = a | b;
            4'd4: c = a ^ b;
            default: c = ~a;
        endcase
        return {v, c};
    endfunction

    always_comb {alu_ovf, alu_c} = alu_ref(alu_func, alu_a, alu_b);

    // Reference model: apply one whole instruction to the architectural state.
    task automatic model_exec(input logic [3:0] f, input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd);
        logic [W:0] r;
        r = alu_ref(f, m_rf[rs], m_rf[rt]);
        m_result = r[W-1:0];
        m_rovf   = r[W];
        if (r[W]) m_sticky = 1'b1;
`ifdef ALU_OVF_TRAP_EN
        if (!r[W]) m_rf[rd] = r[W-1:0];
`else
        m_rf[rd] = r[W-1:0];
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
        m_sticky = 1'b0; m_result = '0; m_rovf = 1'b0;
    endtask

    // Driver tasks. Each one starts and ends 1 ns after a rising edge.
    task automatic host_write(input logic [1:0] a, input logic [W-1:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(posedge clk); #1;
        host_we = 1'b0;
        m_rf[a] = d;
        $display("host write r%0d = %h", a, d);
    endtask

    task automatic drive_issue(input logic [3:0] f, input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd);
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        if (instr_ready !== 1'b1) begin
            n_checks++; n_errors++;
            $display("FAIL issue_timeout instr_ready=%b required 1", instr_ready);
        end
        instr = {f, rs, rt, rd, 6'($urandom_range(0, 63))};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        $display("issue func=%h rs=%0d rt=%0d rd=%0d", f, rs, rt, rd);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready got %b want 1", instr_ready); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done got %b want 0", done); end
        n_checks++; if (alu_a !== '0 || alu_b !== '0) begin n_errors++; $display("FAIL rst_ops got %h/%h want 0/0", alu_a, alu_b); end
        n_checks++; if (alu_func !== 4'hF) begin n_errors++; $display("FAIL rst_func got %h want f", alu_func); end
        n_checks++; if (result !== '0 || result_ovf !== 1'b0 || ovf_sticky !== 1'b0) begin
            n_errors++; $display("FAIL rst_res got %h/%b/%b want 0/0/0", result, result_ovf, ovf_sticky); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i); #1;
            n_checks++; if (rd_data !== '0) begin n_errors++; $display("FAIL rst_rf%0d got %h want 0", i, rd_data); end
        end
        // Present an instruction before the first edge after release; that edge must accept it.
        @(negedge clk);
        reset = 1'b0;
        instr = {4'd3, 2'd1, 2'd2, 2'd0, 6'd0};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        $display("issue func=3 rs=1 rt=2 rd=0 (first edge after reset)");
        model_exec(4'd3, 2'd1, 2'd2, 2'd0);
        n_checks++; if (instr_ready !== 1'b0 || alu_func !== 4'd3) begin
            n_errors++; $display("FAIL first_accept ready=%b func=%h want 0/3", instr_ready, alu_func); end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_directed();
        host_write(2'd0, 16'h0003);
        host_write(2'd1, 16'h0004);
        rd_addr = 2'd2;
        drive_issue(4'd0, 2'd0, 2'd1, 2'd2);
        n_checks++; if (alu_a !== 16'h0003 || alu_b !== 16'h0004 || alu_func !== 4'd0) begin
            n_errors++; $display("FAIL dir_exec got a=%h b=%h f=%h want 0003/0004/0", alu_a, alu_b, alu_func); end
        n_checks++; if (done !== 1'b0 || instr_ready !== 1'b0) begin
            n_errors++; $display("FAIL dir_exec_flags done=%b ready=%b want 0/0", done, instr_ready); end
        model_exec(4'd0, 2'd0, 2'd1, 2'd2);
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b1 || result !== 16'h0007 || result_ovf !== 1'b0) begin
            n_errors++; $display("FAIL dir_done done=%b res=%h ovf=%b want 1/0007/0", done, result, result_ovf); end
        n_checks++; if (rd_data !== 16'h0007) begin n_errors++; $display("FAIL dir_rf2 got %h want 0007", rd_data); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || instr_ready !== 1'b1) begin
            n_errors++; $display("FAIL dir_idle done=%b ready=%b want 0/1", done, instr_ready); end
    endtask

    task automatic test_overflow();
        host_write(2'd0, 16'h7FFF);
        host_write(2'd1, 16'h0001);
        host_write(2'd3, 16'h1234);
        rd_addr = 2'd3;
        drive_issue(4'd0, 2'd0, 2'd1, 2'd3);
        model_exec(4'd0, 2'd0, 2'd1, 2'd3);
        @(posedge clk); #1;
        n_checks++; if (result !== 16'h8000 || result_ovf !== 1'b1 || ovf_sticky !== 1'b1) begin
            n_errors++; $display("FAIL ovf_res res=%h ovf=%b sticky=%b want 8000/1/1", result, result_ovf, ovf_sticky); end
        n_checks++; if (rd_data !== m_rf[3]) begin n_errors++; $display("FAIL ovf_rf3 got %h want %h", rd_data, m_rf[3]); end
        @(posedge clk); #1;
    endtask

    task automatic test_ovf_clr();
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        m_sticky = 1'b0;
        n_checks++; if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL clr_only got %b want 0", ovf_sticky); end
        drive_issue(4'd0, 2'd0, 2'd1, 2'd2);
        ovf_clr = 1'b1;
        model_exec(4'd0, 2'd0, 2'd1, 2'd2);
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        n_checks++; if (ovf_sticky !== 1'b1) begin n_errors++; $display("FAIL clr_vs_set got %b want 1", ovf_sticky); end
        @(posedge clk); #1;
    endtask

    task automatic test_collision();
        logic [W-1:0] hv;
        hv = W'($urandom);
        host_write(2'd0, 16'h00F0);
        host_write(2'd1, 16'h0F0F);
        // Host write to the destination on the writeback edge: the writeback wins.
        rd_addr = 2'd2;
        drive_issue(4'd4, 2'd0, 2'd1, 2'd2);
        host_we = 1'b1; host_addr = 2'd2; host_wdata = hv;
        model_exec(4'd4, 2'd0, 2'd1, 2'd2);
        @(posedge clk); #1;
        host_we = 1'b0;
        n_checks++; if (rd_data !== 16'h0FFF) begin n_errors++; $display("FAIL coll_same got %h want 0fff", rd_data); end
        @(posedge clk); #1;
        // Host write to another register on the writeback edge: both writes land.
        drive_issue(4'd3, 2'd0, 2'd1, 2'd3);
        host_we = 1'b1; host_addr = 2'd1; host_wdata = hv;
        model_exec(4'd3, 2'd0, 2'd1, 2'd3);
        @(posedge clk); #1;
        host_we = 1'b0;
        m_rf[1] = hv;
        rd_addr = 2'd1; #1;
        n_checks++; if (rd_data !== hv) begin n_errors++; $display("FAIL coll_diff_host got %h want %h", rd_data, hv); end
        rd_addr = 2'd3; #1;
        n_checks++; if (rd_data !== 16'h0FFF) begin n_errors++; $display("FAIL coll_diff_wb got %h want 0fff", rd_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        host_write(2'd0, 16'h0003);
        host_write(2'd1, 16'h0004);
        instr = {4'd0, 2'd0, 2'd1, 2'd2, 6'd0};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        $display("issue func=0 rs=0 rt=1 rd=2 (back-to-back 1)");
        model_exec(4'd0, 2'd0, 2'd1, 2'd2);
        instr = {4'd1, 2'd2, 2'd0, 2'd2, 6'd0};
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL b2b_done1 got %b want 1", done); end
        @(posedge clk); #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready got %b want 1", instr_ready); end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        $display("issue func=1 rs=2 rt=0 rd=2 (back-to-back 2)");
        n_checks++; if (alu_a !== 16'h0007 || alu_b !== 16'h0003 || alu_func !== 4'd1) begin
            n_errors++; $display("FAIL b2b_ops got a=%h b=%h f=%h want 0007/0003/1", alu_a, alu_b, alu_func); end
        model_exec(4'd1, 2'd2, 2'd0, 2'd2);
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b1 || result !== 16'h0004) begin
            n_errors++; $display("FAIL b2b_res done=%b res=%h want 1/0004", done, result); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int n_acc = 0, n_done = 0, n_ready = 0;
        logic [3:0] f; logic [1:0] rs, rt, rd;
        logic was_ready;
        logic [W-1:0] ea, eb;
        instr_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            was_ready = instr_ready;
            if (was_ready) begin
                n_ready++;
                f = 4'($urandom_range(0, 5)); rs = 2'($urandom); rt = 2'($urandom); rd = 2'($urandom);
                instr = {f, rs, rt, rd, 6'($urandom_range(0, 63))};
                ea = m_rf[rs]; eb = m_rf[rt];
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n_done++;
                n_checks++; if (result !== m_result || result_ovf !== m_rovf) begin
                    n_errors++; $display("FAIL stream_res got %h/%b want %h/%b", result, result_ovf, m_result, m_rovf); end
            end
            if (was_ready) begin
                n_acc++;
                $display("issue func=%h rs=%0d rt=%0d rd=%0d (stream)", f, rs, rt, rd);
                n_checks++; if (alu_a !== ea || alu_b !== eb || alu_func !== f) begin
                    n_errors++; $display("FAIL stream_ops got %h/%h/%h want %h/%h/%h", alu_a, alu_b, alu_func, ea, eb, f); end
                model_exec(f, rs, rt, rd);
            end
        end
        instr_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (done === 1'b1) n_done++; end
        n_checks++; if (n_ready != 10) begin n_errors++; $display("FAIL stream_ready_cycles got %0d want 10", n_ready); end
        n_checks++; if (n_done != n_acc) begin n_errors++; $display("FAIL stream_done_count got %0d want %0d", n_done, n_acc); end
        n_checks++; if (ovf_sticky !== m_sticky) begin n_errors++; $display("FAIL stream_sticky got %b want %b", ovf_sticky, m_sticky); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i); #1;
            n_checks++; if (rd_data !== m_rf[i]) begin n_errors++; $display("FAIL stream_rf%0d got %h want %h", i, rd_data, m_rf[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [3:0] f; logic [1:0] rs, rt, rd;
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 1) host_write(2'($urandom), W'($urandom));
            f = 4'($urandom_range(0, 6)); rs = 2'($urandom); rt = 2'($urandom); rd = 2'($urandom);
            if (k % 3 == 0) rt = rs;
            rd_addr = rd;
            drive_issue(f, rs, rt, rd);
            n_checks++; if (alu_a !== m_rf[rs] || alu_b !== m_rf[rt] || alu_func !== f) begin
                n_errors++; $display("FAIL rand_ops got %h/%h/%h want %h/%h/%h", alu_a, alu_b, alu_func, m_rf[rs], m_rf[rt], f); end
            model_exec(f, rs, rt, rd);
            @(posedge clk); #1;
            n_checks++; if (done !== 1'b1 || result !== m_result || result_ovf !== m_rovf || rd_data !== m_rf[rd]) begin
                n_errors++; $display("FAIL rand_done done=%b res=%h ovf=%b rf=%h want 1/%h/%b/%h",
                                     done, result, result_ovf, rd_data, m_result, m_rovf, m_rf[rd]); end
            n_checks++; if (ovf_sticky !== m_sticky) begin n_errors++; $display("FAIL rand_sticky got %b want %b", ovf_sticky, m_sticky); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort();
        int n_done = 0;
        host_write(2'd0, 16'h7FFF);
        host_write(2'd1, 16'h0001);
        host_write(2'd3, 16'h5555);
        rd_addr = 2'd3;
        drive_issue(4'd0, 2'd0, 2'd1, 2'd3);
        #1 reset = 1'b1;
        #1;
        model_reset();
        n_checks++; if (done !== 1'b0 || instr_ready !== 1'b1 || alu_a !== '0 || alu_b !== '0 || alu_func !== 4'hF) begin
            n_errors++; $display("FAIL abort_outs done=%b ready=%b a=%h b=%h f=%h want 0/1/0/0/f", done, instr_ready, alu_a, alu_b, alu_func); end
        n_checks++; if (result !== '0 || result_ovf !== 1'b0 || ovf_sticky !== 1'b0 || rd_data !== '0) begin
            n_errors++; $display("FAIL abort_state res=%h ovf=%b sticky=%b rf3=%h want 0/0/0/0", result, result_ovf, ovf_sticky, rd_data); end
        repeat (2) begin @(posedge clk); #1; if (done === 1'b1) n_done++; end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; if (done === 1'b1) n_done++; end
        n_checks++; if (n_done != 0) begin n_errors++; $display("FAIL abort_no_done got %0d pulses want 0", n_done); end
        n_checks++; if (rd_data !== '0 || ovf_sticky !== 1'b0) begin
            n_errors++; $display("FAIL abort_after rf3=%h sticky=%b want 0/0", rd_data, ovf_sticky); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_ovf_clr();
        test_collision();
        test_back_to_back();
        test_stream();
        test_random();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
